// File: rtl/byte_pair_display_if.sv
// Bus between the value source (a, b, load) and the decimal display block.
interface byte_pair_display_if;
   logic [7:0] a;
   logic [7:0] b;
   logic       load;
   logic       busy;
   logic       done;
   logic [6:0] hex0;
   logic [6:0] hex1;
   logic [6:0] hex2;
   logic [6:0] hex3;
   logic [6:0] hex4;
   logic [6:0] hex5;

   modport master (
      output a, b, load,
      input  busy, done, hex0, hex1, hex2, hex3, hex4, hex5
   );

   modport slave (
      input  a, b, load,
      output busy, done, hex0, hex1, hex2, hex3, hex4, hex5
   );
endinterface

// File: rtl/byte_pair_display.sv
// Shows two bytes as 3-digit decimal numbers on six seven-segment digits.
// A sequential double-dabble engine converts a then b, one bit per clock,
// and the display registers are rewritten together once both are done.
module byte_pair_display #(
   parameter bit INVERT_SEG    = 1'b1,
   parameter bit BLANK_LEADING = 1'b1
) (
   input logic                clk,
   input logic                rst,
   byte_pair_display_if.slave bus
);

   localparam logic [6:0] SEG_BLANK = INVERT_SEG ? 7'h7F : 7'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV_A = 2'd1,
      CONV_B = 2'd2,
      UPDATE = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [2:0]  cnt_r;
   logic [7:0]  bin_r;
   logic [7:0]  shadow_b_r;
   logic [11:0] bcd_r;
   logic [11:0] bcd_a_r;
   logic [11:0] bcd_adj_s;
   logic [11:0] bcd_shift_s;
   logic        capture_s;
   logic        busy_next_s;
   logic        done_next_s;
   logic        busy_r;
   logic        done_r;
   logic [6:0]  disp_s [6];
   logic [6:0]  hex_r [6];

   // Double-dabble correction: every BCD nibble of 5 or more gets 3 added
   // so that the following left shift carries correctly into the next digit.
   function automatic logic [11:0] add3_nibbles(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? (v[i*4 +: 4] + 4'd3) : v[i*4 +: 4];
      end
      return r;
   endfunction

   // Seven-segment pattern for one digit (bit0 = seg a), blanked on request,
   // then adjusted to the board's segment polarity.
   function automatic logic [6:0] seg_code(input logic [3:0] nib, input logic blank);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      s = blank ? 7'h00 : s;
      return INVERT_SEG ? ~s : s;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: each conversion phase runs for exactly 8 bit-steps.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = bus.load ? CONV_A : IDLE;
         CONV_A:  state_next_s = (cnt_r == 3'd7) ? CONV_B : CONV_A;
         CONV_B:  state_next_s = (cnt_r == 3'd7) ? UPDATE : CONV_B;
         UPDATE:  state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Output decode: busy follows the upcoming state so that it is registered,
   // done marks the cycle right after the display write.
   always_comb begin
      capture_s   = 1'b0;
      busy_next_s = 1'b0;
      done_next_s = 1'b0;
      if (state_r == IDLE) begin
         capture_s = bus.load;
      end else begin
         capture_s = 1'b0;
      end
      busy_next_s = (state_next_s != IDLE);
      done_next_s = (state_r == UPDATE);
   end

   // One shift-add-3 step on the current BCD accumulator.
   always_comb begin
      bcd_adj_s   = add3_nibbles(bcd_r);
      bcd_shift_s = {bcd_adj_s[10:0], bin_r[7]};
   end

   // Conversion datapath: capture on load, shift a, park its result, shift b.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r      <= 3'd0;
         bin_r      <= 8'd0;
         shadow_b_r <= 8'd0;
         bcd_r      <= 12'd0;
         bcd_a_r    <= 12'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (capture_s) begin
                  bin_r      <= bus.a;
                  shadow_b_r <= bus.b;
                  bcd_r      <= 12'd0;
                  cnt_r      <= 3'd0;
               end
            end
            CONV_A: begin
               cnt_r <= cnt_r + 3'd1;
               if (cnt_r == 3'd7) begin
                  bcd_a_r <= bcd_shift_s;
                  bcd_r   <= 12'd0;
                  bin_r   <= shadow_b_r;
               end else begin
                  bcd_r <= bcd_shift_s;
                  bin_r <= {bin_r[6:0], 1'b0};
               end
            end
            CONV_B: begin
               cnt_r <= cnt_r + 3'd1;
               bcd_r <= bcd_shift_s;
               bin_r <= {bin_r[6:0], 1'b0};
            end
            UPDATE: begin
               cnt_r <= 3'd0;
            end
            default: begin
               cnt_r <= 3'd0;
            end
         endcase
      end
   end

   // Digit patterns with optional leading-zero suppression; ones always shown.
   always_comb begin
      disp_s[0] = seg_code(bcd_a_r[3:0], 1'b0);
      disp_s[1] = seg_code(bcd_a_r[7:4],
                           BLANK_LEADING && (bcd_a_r[11:8] == 4'd0) && (bcd_a_r[7:4] == 4'd0));
      disp_s[2] = seg_code(bcd_a_r[11:8], BLANK_LEADING && (bcd_a_r[11:8] == 4'd0));
      disp_s[3] = seg_code(bcd_r[3:0], 1'b0);
      disp_s[4] = seg_code(bcd_r[7:4],
                           BLANK_LEADING && (bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0));
      disp_s[5] = seg_code(bcd_r[11:8], BLANK_LEADING && (bcd_r[11:8] == 4'd0));
   end

   // Output registers: hex digits change only in UPDATE, status flags every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            hex_r[i] <= SEG_BLANK;
         end
      end else begin
         busy_r <= busy_next_s;
         done_r <= done_next_s;
         if (state_r == UPDATE) begin
            for (int i = 0; i < 6; i++) begin
               hex_r[i] <= disp_s[i];
            end
         end
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hex0 = hex_r[0];
   assign bus.hex1 = hex_r[1];
   assign bus.hex2 = hex_r[2];
   assign bus.hex3 = hex_r[3];
   assign bus.hex4 = hex_r[4];
   assign bus.hex5 = hex_r[5];

endmodule

// File: tb/tb_byte_pair_display.sv
// Bench for byte_pair_display (INVERT_SEG=1, BLANK_LEADING=1): directed cases
// plus a back-to-back sweep, checked against a decimal-arithmetic display model.
module tb_byte_pair_display;

   logic clk;
   logic rst;
   int   vectors;
   int   errors;

   logic [7:0]  last_a;
   logic [7:0]  last_b;
   bit          last_valid;
   logic [41:0] blank_all;
   logic [6:0]  seg_tab [0:9];

   byte_pair_display_if bus ();

   byte_pair_display #(
      .INVERT_SEG    (1'b1),
      .BLANK_LEADING (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Three digit codes {hundreds, tens, ones} of one value, active-low.
   function automatic logic [20:0] ref_digits(input int v);
      int h;
      int t;
      int o;
      logic [6:0] hc;
      logic [6:0] tc;
      logic [6:0] oc;
      h  = v / 100;
      t  = (v / 10) % 10;
      o  = v % 10;
      oc = ~seg_tab[o];
      tc = (h == 0 && t == 0) ? 7'h7F : ~seg_tab[t];
      hc = (h == 0) ? 7'h7F : ~seg_tab[h];
      return {hc, tc, oc};
   endfunction

   function automatic logic [41:0] model_disp(input int va, input int vb);
      return {ref_digits(vb), ref_digits(va)};
   endfunction

   function automatic logic [41:0] hex_obs();
      return {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
   endfunction

   // One conversion starting at a negedge. Returns in the done cycle
   // (timing=0, ready for a back-to-back load) or one cycle later (timing=1).
   // inj_k >= 0 re-pulses load with a=99 on edge E0+inj_k+1.
   task automatic do_convert(input logic [7:0] va, input logic [7:0] vb,
                             input bit timing, input int inj_k);
      int k;
      int busy_cnt;
      bit got;
      bus.a    = va;
      bus.b    = vb;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      bus.a    = 8'($urandom);
      bus.b    = 8'($urandom);
      k        = 0;
      busy_cnt = 0;
      got      = 1'b0;
      while (!got && k < 40) begin
         if (k == inj_k) begin
            bus.load = 1'b1;
            bus.a    = 8'd99;
         end else if (k == inj_k + 1) begin
            bus.load = 1'b0;
         end
         if (k == 8) begin
            check("hold", 64'(hex_obs()),
                  last_valid ? 64'(model_disp(int'(last_a), int'(last_b))) : 64'(blank_all));
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            got = 1'b1;
         end else begin
            @(negedge clk);
            k++;
         end
      end
      bus.load = 1'b0;
      check("done_seen", 64'(got), 64'd1);
      if (got && timing) begin
         check("latency", 64'(k), 64'd17);
         check("busy_cycles", 64'(busy_cnt), 64'd17);
      end
      check("display", 64'(hex_obs()), 64'(model_disp(int'(va), int'(vb))));
      last_a     = va;
      last_b     = vb;
      last_valid = 1'b1;
      if (timing) begin
         @(negedge clk);
         check("done_width", 64'(bus.done), 64'd0);
         check("busy_idle", 64'(bus.busy), 64'd0);
      end
   endtask

   initial begin
      bit saw_done;
      vectors    = 0;
      errors     = 0;
      last_valid = 1'b0;
      last_a     = 8'd0;
      last_b     = 8'd0;
      blank_all  = {6{7'h7F}};
      seg_tab    = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      rst        = 1'b1;
      bus.load   = 1'b0;
      bus.a      = 8'd0;
      bus.b      = 8'd0;

      // Reset held for two clocks.
      repeat (2) @(negedge clk);
      check("rst_hex", 64'(hex_obs()), 64'(blank_all));
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed values with exact timing.
      do_convert(8'd0, 8'd255, 1'b1, -1);
      check("t2_const", 64'(hex_obs()), 64'({7'h24, 7'h12, 7'h12, 7'h7F, 7'h7F, 7'h40}));
      do_convert(8'd100, 8'd7, 1'b1, -1);
      check("t3_const", 64'(hex_obs()), 64'({7'h7F, 7'h7F, 7'h78, 7'h79, 7'h40, 7'h40}));
      do_convert(8'd42, 8'd0, 1'b1, 4);
      check("t4_const", 64'(hex_obs()), 64'({7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h19, 7'h24}));

      // Reset in the middle of a conversion.
      bus.a    = 8'd200;
      bus.b    = 8'd13;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_hex", 64'(hex_obs()), 64'(blank_all));
      rst        = 1'b0;
      last_valid = 1'b0;
      saw_done   = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'd0);

      // Reset and load on the same edge: reset wins.
      rst      = 1'b1;
      bus.load = 1'b1;
      bus.a    = 8'd5;
      @(negedge clk);
      rst      = 1'b0;
      bus.load = 1'b0;
      check("rst_load_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("rst_load_idle", 64'(bus.busy), 64'd0);

      do_convert(8'd200, 8'd13, 1'b1, -1);

      // Back-to-back sweep of a over 0..255 with random b.
      for (int i = 0; i < 256; i++) begin
         do_convert(8'(i), 8'($urandom_range(0, 255)), 1'b0, -1);
      end
      @(negedge clk);

      // Random pairs with full timing checks.
      for (int i = 0; i < 12; i++) begin
         do_convert(8'($urandom), 8'($urandom), 1'b1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
